// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared constants and writeback entry type for the FPU
//                writeback queues (fsub, fmul, fdiv).
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

   localparam int FPU_TAG_W  = 6;    // destination register tag width
   localparam int FSUB_LAT   = 2;    // fadd/fsub datapath latency in edges
   localparam int FPU_DATA_W = 32;   // result width

   // One buffered result on its way to the FPR write port
   typedef struct packed {
      logic [FPU_TAG_W-1:0]  rd;
      logic [FPU_DATA_W-1:0] data;
      logic                  ovf;
   } wb_entry_t;

   // Bundle a captured result into a writeback entry
   function automatic wb_entry_t make_wb_entry(input logic [FPU_TAG_W-1:0]  rd,
                                               input logic [FPU_DATA_W-1:0] data,
                                               input logic                  ovf);
      wb_entry_t e;
      e.rd   = rd;
      e.data = data;
      e.ovf  = ovf;
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_wb_fifo
//  Description : Parameterised synchronous circular FIFO with push, pop,
//                clear, full, empty and count. Head is read combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_wb_fifo #(
   parameter int WIDTH = 39,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   // Pointer advance with explicit wrap so non-power-of-two depths work
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full FIFO is only legal when the head leaves the same cycle
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign full     = (cnt == CNT_W'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/fsub_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fsub_wb_queue
//  Description : Writeback companion to the fixed-latency fadd/fsub
//                datapath. Tracks valid/rd tags alongside the datapath,
//                captures results into a FIFO and hands them to the FPR
//                write port with credit-based issue throttling.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsub_wb_queue
   import fpu_pkg::*;
#(
   parameter int LAT   = FSUB_LAT,
   parameter int DEPTH = 4,
   parameter int TAG_W = FPU_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             iss_valid,
   output logic             iss_ready,
   input  logic [TAG_W-1:0] iss_rd,
   input  logic [31:0]      res_y,
   input  logic             res_ovf,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [TAG_W-1:0] wb_rd,
   output logic [31:0]      wb_data,
   output logic             wb_ovf
);

   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = TAG_W + 33;

   logic [LAT-1:0]     pipe_v;
   logic [TAG_W-1:0]   pipe_rd [LAT];
   logic [CNT_W-1:0]   used;
   logic               accept;
   logic               handshake;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               unused_fifo_status;

   // Issue side: credits depend only on registered state plus rst/flush
   assign iss_ready = !rst && !flush && (used < CNT_W'(DEPTH));
   assign accept    = iss_valid && iss_ready;
   assign handshake = wb_valid && wb_ready;

   // A flush discards both the pending capture and the pending retire
   assign fifo_push = pipe_v[LAT-1] && !flush;
   assign fifo_pop  = handshake && !flush;

   // Valid half of the tag pipe; always shifts, killed by reset or flush
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pipe_v <= '0;
      end else begin
         pipe_v[0] <= accept;
         for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];
      end
   end

   // Tag half of the tag pipe; only meaningful where the matching valid is set
   always_ff @(posedge clk) begin
      pipe_rd[0] <= iss_rd;
      for (int i = 1; i < LAT; i++) pipe_rd[i] <= pipe_rd[i-1];
   end

   // Credit counter: ops in flight plus ops buffered
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         used <= '0;
      end else begin
         case ({accept, handshake})
            2'b10:   used <= used + 1'b1;
            2'b01:   used <= used - 1'b1;
            default: used <= used;
         endcase
      end
   end

   fpu_wb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (fifo_push),
      .push_data ({pipe_rd[LAT-1], res_y, res_ovf}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Occupancy is tracked by the credit counter; these are informational here
   assign unused_fifo_status = ^{fifo_full, fifo_count};

   // Head presentation, forced to zero whenever nothing is offered
   assign wb_valid = !rst && !fifo_empty;
   assign wb_rd    = wb_valid ? fifo_head[ENTRY_W-1:33] : '0;
   assign wb_data  = wb_valid ? fifo_head[32:1]         : '0;
   assign wb_ovf   = wb_valid ? fifo_head[0]            : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fsub_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsub_wb_queue
//  Description : Self-checking bench for fsub_wb_queue. A delay-line stub
//                stands in for the fsub datapath; a queue-based model
//                predicts issue credits and writeback beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsub_wb_queue;

   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int TAG_W = 6;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             iss_valid;
   logic             iss_ready;
   logic [TAG_W-1:0] iss_rd;
   logic [31:0]      res_y;
   logic             res_ovf;
   logic             wb_valid;
   logic             wb_ready;
   logic [TAG_W-1:0] wb_rd;
   logic [31:0]      wb_data;
   logic             wb_ovf;

   // Value the issue stage's operands would produce once through the datapath
   logic [31:0] cur_y;
   logic        cur_ovf;
   logic [31:0] dp_y   [LAT];
   logic        dp_ovf [LAT];

   int checks = 0;
   int errors = 0;

   fsub_wb_queue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .iss_rd    (iss_rd),
      .res_y     (res_y),
      .res_ovf   (res_ovf),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_ovf    (wb_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath stand-in: pure LAT-edge delay of the precomputed result
   always @(posedge clk) begin
      dp_y[0]   <= cur_y;
      dp_ovf[0] <= cur_ovf;
      for (int i = 1; i < LAT; i++) begin
         dp_y[i]   <= dp_y[i-1];
         dp_ovf[i] <= dp_ovf[i-1];
      end
   end
   assign res_y   = dp_y[LAT-1];
   assign res_ovf = dp_ovf[LAT-1];

   // Overflow guard: capturing into a full buffer without a retire is illegal
   always @(negedge clk) begin
      if (!rst && dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) begin
         errors++;
         $display("FAIL fifo_overflow: push into full buffer at time %0t", $time);
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [TAG_W-1:0] rd;
      logic [31:0]      data;
      logic             ovf;
      int               due;
   } op_t;

   op_t inflight[$];
   op_t buffered[$];
   int  cyc = 0;
   logic exp_ready, exp_valid, m_acc, m_hs;
   logic obs_acc, obs_beat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic iv, input logic [TAG_W-1:0] rd, input logic [31:0] y,
                        input logic ovf, input logic wr, input logic fl, input logic rs);
      iss_valid = iv;
      iss_rd    = rd;
      cur_y     = y;
      cur_ovf   = ovf;
      wb_ready  = wr;
      flush     = fl;
      rst       = rs;
   endtask

   // Mid-cycle: compare DUT against model and decide this cycle's events
   task automatic sample();
      @(negedge clk);
      exp_ready = !rst && !flush && ((inflight.size() + buffered.size()) < DEPTH);
      exp_valid = !rst && (buffered.size() != 0);
      check("iss_ready", iss_ready, exp_ready);
      check("wb_valid", wb_valid, exp_valid);
      if (exp_valid) begin
         check("wb_rd", wb_rd, buffered[0].rd);
         check("wb_data", wb_data, buffered[0].data);
         check("wb_ovf", wb_ovf, buffered[0].ovf);
      end else if (rst) begin
         check("rst_wb_rd", wb_rd, 0);
         check("rst_wb_data", wb_data, 0);
         check("rst_wb_ovf", wb_ovf, 0);
      end
      m_acc    = iss_valid && exp_ready;
      m_hs     = exp_valid && wb_ready;
      obs_acc  = iss_valid && iss_ready;
      obs_beat = wb_valid && wb_ready;
   endtask

   // Clock edge: apply the model's rules for that edge
   task automatic advance();
      op_t o;
      @(posedge clk);
      if (rst || flush) begin
         inflight.delete();
         buffered.delete();
      end else begin
         if (m_hs) void'(buffered.pop_front());
         while (inflight.size() > 0 && inflight[0].due == cyc)
            buffered.push_back(inflight.pop_front());
         if (m_acc) begin
            o.rd = iss_rd; o.data = cur_y; o.ovf = cur_ovf; o.due = cyc + LAT;
            inflight.push_back(o);
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n, input logic wr);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, '0, 32'h0, 1'b0, wr, 1'b0, 1'b0);
         sample();
         advance();
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic             iv;
      logic [TAG_W-1:0] rd;
      logic [31:0]      y;
      logic             ovf;
      logic             wr;
      logic             ex_ready;
      logic             ex_valid;
      logic [TAG_W-1:0] ex_rd;
      logic [31:0]      ex_data;
      logic             ex_ovf;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [TAG_W-1:0] rd, input logic [31:0] y,
                               input logic ovf, input logic exr, input logic exv,
                               input logic [TAG_W-1:0] exrd, input logic [31:0] exd,
                               input logic exo);
      vec_t v;
      v.iv = iv; v.rd = rd; v.y = y; v.ovf = ovf; v.wr = 1'b1;
      v.ex_ready = exr; v.ex_valid = exv; v.ex_rd = exrd; v.ex_data = exd; v.ex_ovf = exo;
      return v;
   endfunction

   vec_t vt[13];
   int   n_acc;
   int   n_beat;

   initial begin
      // single op: 3.0 - 1.0 leaves the datapath as 2.0
      vt[0]  = mk(1, 5, 32'h4000_0000, 0, 1, 0, 0, 32'h0, 0);
      vt[1]  = mk(0, 0, 32'h0,         0, 1, 0, 0, 32'h0, 0);
      vt[2]  = mk(0, 0, 32'h0,         0, 1, 0, 0, 32'h0, 0);
      vt[3]  = mk(0, 0, 32'h0,         0, 1, 1, 5, 32'h4000_0000, 0);
      vt[4]  = mk(0, 0, 32'h0,         0, 1, 0, 0, 32'h0, 0);
      // four back-to-back issues retire in order three cycles later
      vt[5]  = mk(1, 1, 32'h3F80_0000, 0, 1, 0, 0, 32'h0, 0);
      vt[6]  = mk(1, 2, 32'h4040_0000, 0, 1, 0, 0, 32'h0, 0);
      vt[7]  = mk(1, 3, 32'hC000_0000, 0, 1, 0, 0, 32'h0, 0);
      vt[8]  = mk(1, 4, 32'h7F80_0000, 1, 1, 1, 1, 32'h3F80_0000, 0);
      vt[9]  = mk(0, 0, 32'h0,         0, 1, 1, 2, 32'h4040_0000, 0);
      vt[10] = mk(0, 0, 32'h0,         0, 1, 1, 3, 32'hC000_0000, 0);
      vt[11] = mk(0, 0, 32'h0,         0, 1, 1, 4, 32'h7F80_0000, 1);
      vt[12] = mk(0, 0, 32'h0,         0, 1, 0, 0, 32'h0, 0);

      // reset with issue requests pending: nothing may be accepted
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 6'd9, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1);
         sample();
         advance();
      end

      // table-driven directed vectors
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].iv, vt[i].rd, vt[i].y, vt[i].ovf, vt[i].wr, 1'b0, 1'b0);
         sample();
         check($sformatf("vec%0d_ready", i), iss_ready, vt[i].ex_ready);
         check($sformatf("vec%0d_valid", i), wb_valid, vt[i].ex_valid);
         if (vt[i].ex_valid) begin
            check($sformatf("vec%0d_rd", i), wb_rd, vt[i].ex_rd);
            check($sformatf("vec%0d_data", i), wb_data, vt[i].ex_data);
            check($sformatf("vec%0d_ovf", i), wb_ovf, vt[i].ex_ovf);
         end
         advance();
      end

      // backpressure: only DEPTH accepts while the write port stalls
      n_acc = 0;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, TAG_W'(10 + i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
         sample();
         if (obs_acc) n_acc++;
         advance();
      end
      check("bp_accepts", n_acc, DEPTH);
      // full: retire and issue request together, credit returns next cycle
      drive(1'b1, 6'd20, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
      sample();
      check("full_ready_same_cycle", iss_ready, 0);
      check("full_valid_same_cycle", wb_valid, 1);
      check("full_head_rd", wb_rd, 10);
      advance();
      drive(1'b1, 6'd21, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
      sample();
      check("full_ready_next_cycle", iss_ready, 1);
      advance();
      n_acc = 0; n_beat = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, TAG_W'(22 + i), $urandom, 1'(i), 1'b1, 1'b0, 1'b0);
         sample();
         if (obs_acc) n_acc++;
         if (obs_beat) n_beat++;
         advance();
      end
      check("drain_beats", n_beat, 8);
      idle(8, 1'b1);

      // flush with two ops in flight and two buffered
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, TAG_W'(40 + i), 32'hDEAD_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
         sample();
         advance();
      end
      drive(1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      sample();
      check("flush_cycle_valid", wb_valid, 1);
      advance();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
         sample();
         check("post_flush_valid", wb_valid, 0);
         if (i == 0) check("post_flush_ready", iss_ready, 1);
         advance();
      end

      // reset with three ops outstanding
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, TAG_W'(50 + i), 32'hBEEF_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
         sample();
         advance();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 6'd60, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
         sample();
         check("rst_ready", iss_ready, 0);
         check("rst_valid", wb_valid, 0);
         advance();
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
         sample();
         check("post_rst_valid", wb_valid, 0);
         check("post_rst_ready", iss_ready, 1);
         advance();
      end

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         drive(($urandom % 4) != 0, TAG_W'($urandom), $urandom, 1'($urandom),
               ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 90) == 0);
         sample();
         advance();
      end
      idle(10, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
